// File: rtl/mc_sequencer_if.sv
// Memory handshake bundle between the multicycle sequencer and its
// instruction/data memories. The sequencer is the master; memories are slaves.
interface mc_sequencer_if #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32
);
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_ready;
    logic [INST_SIZE-1:0] imem_rdata;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle LEGv8 sequencer: owns PC, IR, retire counter and the phase FSM.
// Each instruction walks FETCH/DECODE/EXECUTE[/MEM][/WB]; memory requests may
// stall and are bounded by a wait counter that traps into a sticky FAULT state.
module mc_sequencer #(
    parameter int              WORD      = 64,
    parameter int              INST_SIZE = 32,
    parameter logic [WORD-1:0] RESET_PC  = '0,
    parameter int              TIMEOUT   = 15,
    parameter int              CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mc_sequencer_if.master       mem,
    input  logic [1:0]           PCSrc,
    input  logic [WORD-1:0]      br_target,
    input  logic [WORD-1:0]      alu_out,
    output logic [INST_SIZE-1:0] inst,
    output logic [WORD-1:0]      pc,
    output logic [WORD-1:0]      pc_incr,
    output logic                 id_en,
    output logic                 ex_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic                 retire,
    output logic [CNT_W-1:0]     instret,
    output logic                 fault
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU    = 3'd0,
        C_LDUR   = 3'd1,
        C_STUR   = 3'd2,
        C_BR     = 3'd3,
        C_BL     = 3'd4,
        C_BRANCH = 3'd5
    } iclass_t;

    // Classify an instruction from its opcode field (IR bits 31:21).
    function automatic iclass_t decode_class(input logic [10:0] op);
        iclass_t cls;
        if (op == 11'h7C2) begin
            cls = C_LDUR;
        end else if (op == 11'h7C0) begin
            cls = C_STUR;
        end else if (op == 11'h6B0) begin
            cls = C_BR;
        end else if (op[10:5] == 6'h25) begin
            cls = C_BL;
        end else if ((op[10:5] == 6'h05) || (op[10:3] == 8'h54) ||
                     (op[10:3] == 8'hB4) || (op[10:3] == 8'hB5)) begin
            cls = C_BRANCH;
        end else begin
            cls = C_ALU;
        end
        return cls;
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic [INST_SIZE-1:0] inst_q, inst_d;
    logic [WORD-1:0]      pc_q, pc_d;
    logic [WORD-1:0]      npc_q, npc_d;
    logic [CNT_W-1:0]     instret_q, instret_d;
    logic                 fault_q, fault_d;

    iclass_t              class_s;
    logic [WORD-1:0]      pc_incr_s;
    logic [WORD-1:0]      npc_s;
    logic                 end_s;
    logic                 imem_req_s, dmem_req_s, dmem_we_s;
    logic                 id_en_s, ex_en_s, mem_en_s, wb_en_s;
    logic                 timeout_s;

    assign pc_incr_s = pc_q + {{(WORD-3){1'b0}}, 3'd4};
    assign timeout_s = (wait_q == 8'(TIMEOUT));

    // Instruction class of the IR contents.
    always_comb begin
        class_s = decode_class(inst_q[31:21]);
    end

    // Next-PC candidate; BR always jumps to the ALU result, PCSrc=3 falls back to pc+4.
    always_comb begin
        npc_s = pc_incr_s;
        if (class_s == C_BR) begin
            npc_s = alu_out;
        end else begin
            case (PCSrc)
                2'd1:    npc_s = br_target;
                2'd2:    npc_s = alu_out;
                default: npc_s = pc_incr_s;
            endcase
        end
    end

    // Phase FSM: next state, datapath register updates and phase enables.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        instret_d  = instret_q;
        fault_d    = fault_q;
        end_s      = 1'b0;
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        id_en_s    = 1'b0;
        ex_en_s    = 1'b0;
        mem_en_s   = 1'b0;
        wb_en_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (mem.imem_ready) begin
                    inst_d  = mem.imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                id_en_s = 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                ex_en_s = 1'b1;
                npc_d   = npc_s;
                case (class_s)
                    C_LDUR, C_STUR: begin
                        state_d = S_MEM;
                        wait_d  = 8'd0;
                    end
                    C_BRANCH, C_BR: begin
                        state_d = S_FETCH;
                        wait_d  = 8'd0;
                        pc_d    = npc_s;
                        end_s   = 1'b1;
                    end
                    default: begin
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                mem_en_s   = 1'b1;
                dmem_req_s = 1'b1;
                dmem_we_s  = (class_s == C_STUR);
                if (mem.dmem_ready) begin
                    if (class_s == C_STUR) begin
                        state_d = S_FETCH;
                        wait_d  = 8'd0;
                        pc_d    = npc_q;
                        end_s   = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                wb_en_s = 1'b1;
                state_d = S_FETCH;
                wait_d  = 8'd0;
                pc_d    = npc_q;
                end_s   = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
        endcase
        if (end_s) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_d;
        end
    end

    // State and architectural registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            inst_q    <= '0;
            pc_q      <= RESET_PC;
            npc_q     <= RESET_PC;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    assign mem.imem_req  = imem_req_s;
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = dmem_req_s;
    assign mem.dmem_we   = dmem_we_s;

    assign inst    = inst_q;
    assign pc      = pc_q;
    assign pc_incr = pc_incr_s;
    assign id_en   = id_en_s;
    assign ex_en   = ex_en_s;
    assign mem_en  = mem_en_s;
    assign wb_en   = wb_en_s;
    assign retire  = end_s;
    assign instret = instret_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer against a per-instruction
// reference model (phase counts, latency, next PC, retire count).
module tb_mc_sequencer;

    localparam int WORD    = 64;
    localparam int ISZ     = 32;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    localparam int C_ALU    = 0;
    localparam int C_LDUR   = 1;
    localparam int C_STUR   = 2;
    localparam int C_BR     = 3;
    localparam int C_BL     = 4;
    localparam int C_BRANCH = 5;

    logic             clk;
    logic             rst_n;
    logic [1:0]       PCSrc;
    logic [WORD-1:0]  br_target;
    logic [WORD-1:0]  alu_out;
    logic [ISZ-1:0]   inst;
    logic [WORD-1:0]  pc;
    logic [WORD-1:0]  pc_incr;
    logic             id_en, ex_en, mem_en, wb_en, retire, fault;
    logic [CNT_W-1:0] instret;

    int n_checks;
    int n_errors;

    logic [WORD-1:0]  m_pc;
    logic [CNT_W-1:0] m_instret;

    mc_sequencer_if #(.WORD(WORD), .INST_SIZE(ISZ)) mif ();

    mc_sequencer #(
        .WORD(WORD), .INST_SIZE(ISZ), .RESET_PC(64'h0),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif),
        .PCSrc(PCSrc), .br_target(br_target), .alu_out(alu_out),
        .inst(inst), .pc(pc), .pc_incr(pc_incr),
        .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .retire(retire), .instret(instret), .fault(fault)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_for(input int cls, input int variant);
        logic [31:0] w;
        case (cls)
            C_LDUR:   w = 32'hF840_0020;
            C_STUR:   w = 32'hF800_0020;
            C_BR:     w = 32'hD61F_0000;
            C_BL:     w = 32'h9400_0004;
            C_BRANCH: begin
                case (variant)
                    0:       w = 32'h5400_0040;
                    1:       w = 32'h1400_0010;
                    2:       w = 32'hB400_0000;
                    default: w = 32'hB500_0020;
                endcase
            end
            default: begin
                case (variant)
                    0:       w = 32'h8B02_0020;
                    1:       w = 32'hCB03_0041;
                    2:       w = 32'h9100_0421;
                    default: w = 32'hAA02_0020;
                endcase
            end
        endcase
        return w;
    endfunction

    // Run one instruction with given memory wait counts and check it against the model.
    task automatic run_instr(input logic [31:0] iword, input int cls, input int iwait,
                             input int dwait, input logic [1:0] psel,
                             input logic [63:0] bt, input logic [63:0] ao);
        int fcnt, mcnt, nd, ne, nw, cyc;
        int exp_mem, exp_wb, exp_cyc;
        logic done;
        logic [63:0] exp_pc;
        if (cls == C_BR)     exp_pc = ao;
        else if (psel == 2'd1) exp_pc = bt;
        else if (psel == 2'd2) exp_pc = ao;
        else                   exp_pc = m_pc + 64'd4;
        exp_mem = (cls == C_LDUR || cls == C_STUR) ? dwait + 1 : 0;
        exp_wb  = (cls == C_ALU || cls == C_BL || cls == C_LDUR) ? 1 : 0;
        exp_cyc = (iwait + 1) + 2 + exp_mem + exp_wb;
        PCSrc = psel; br_target = bt; alu_out = ao;
        fcnt = 0; mcnt = 0; nd = 0; ne = 0; nw = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (mif.imem_req) begin
                check_eq("imem_addr", mif.imem_addr, m_pc);
                mif.imem_ready = (fcnt == iwait);
                mif.imem_rdata = (fcnt == iwait) ? iword : $urandom;
                fcnt++;
            end else begin
                mif.imem_ready = 1'($urandom_range(0, 1));
                mif.imem_rdata = $urandom;
                check_eq("ir_hold", inst, iword);
            end
            if (mif.dmem_req) begin
                check_eq("dmem_we", mif.dmem_we, (cls == C_STUR));
                mif.dmem_ready = (mcnt == dwait);
                mcnt++;
            end else begin
                mif.dmem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            check_eq("onehot", $countones({mif.imem_req, id_en, ex_en, mem_en, wb_en}), 1);
            check_eq("pc_hold", pc, m_pc);
            nd += id_en; ne += ex_en; nw += wb_en;
            cyc++;
            if (retire) done = 1'b1;
        end
        check_eq("retired", done, 1'b1);
        check_eq("cycles", cyc, exp_cyc);
        check_eq("fetch_cycles", fcnt, iwait + 1);
        check_eq("id_cnt", nd, 1);
        check_eq("ex_cnt", ne, 1);
        check_eq("mem_cnt", mcnt, exp_mem);
        check_eq("wb_cnt", nw, exp_wb);
        @(posedge clk);
        #1;
        m_pc = exp_pc;
        m_instret = m_instret + 1'b1;
        check_eq("pc_next", pc, m_pc);
        check_eq("pc_incr", pc_incr, m_pc + 64'd4);
        check_eq("instret", instret, m_instret);
        check_eq("ir", inst, iword);
    endtask

    initial begin
        int cls, iw, dw, nreq;
        logic [63:0] bt, ao;
        clk = 1'b0; rst_n = 1'b0;
        n_checks = 0; n_errors = 0;
        PCSrc = 2'd0; br_target = '0; alu_out = '0;
        mif.imem_ready = 1'b0; mif.imem_rdata = '0; mif.dmem_ready = 1'b0;
        m_pc = 64'h0; m_instret = '0;
        #1;
        check_eq("rst_imem_req", mif.imem_req, 1'b1);
        check_eq("rst_imem_addr", mif.imem_addr, 64'h0);
        check_eq("rst_enables", {id_en, ex_en, mem_en, wb_en, retire, mif.dmem_req}, 6'b0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_instret", instret, 32'h0);
        check_eq("rst_fault", fault, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence from the plan.
        run_instr(32'h8B02_0020, C_ALU,    0, 0, 2'd0, 64'h0,  64'h0);
        run_instr(32'hF840_0020, C_LDUR,   0, 3, 2'd0, 64'h0,  64'h0);
        run_instr(32'hF800_0020, C_STUR,   0, 0, 2'd0, 64'h0,  64'h0);
        run_instr(32'h5400_0040, C_BRANCH, 0, 0, 2'd1, 64'h40, 64'h0);
        run_instr(32'hD61F_0000, C_BR,     0, 0, 2'd0, 64'h0,  64'h100);
        run_instr(32'h9400_0004, C_BL,     TIMEOUT, 0, 2'd1, 64'h200, 64'h0);
        run_instr(32'hF840_0020, C_LDUR,   0, TIMEOUT, 2'd3, 64'h0, 64'h0);

        // Random instruction stream.
        for (int n = 0; n < 200; n++) begin
            cls = $urandom_range(0, 5);
            iw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT) : 0;
            dw  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TIMEOUT) : 0;
            bt  = {$urandom, $urandom};
            ao  = {$urandom, $urandom};
            run_instr(word_for(cls, $urandom_range(0, 3)), cls, iw, dw,
                      2'($urandom_range(0, 3)), bt, ao);
        end

        // Reset in the middle of a load aborts it.
        PCSrc = 2'd0;
        nreq = 0;
        while (!mem_en && nreq < 20) begin
            @(negedge clk);
            mif.imem_ready = mif.imem_req;
            mif.imem_rdata = 32'hF840_0020;
            mif.dmem_ready = 1'b0;
            #1;
            nreq++;
        end
        check_eq("reach_mem", mem_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_pc = 64'h0; m_instret = '0;
        check_eq("abort_pc", pc, 64'h0);
        check_eq("abort_instret", instret, 32'h0);
        check_eq("abort_imem_req", mif.imem_req, 1'b1);
        check_eq("abort_retire", {retire, mem_en, mif.dmem_req}, 3'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(32'h8B02_0020, C_ALU, 0, 0, 2'd0, 64'h0, 64'h0);

        // Fetch that never answers: fault after TIMEOUT wait cycles.
        mif.imem_ready = 1'b0;
        nreq = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mif.imem_ready = 1'b0;
            #1;
            if (!mif.imem_req) break;
            nreq++;
        end
        check_eq("fault_req_cycles", nreq, TIMEOUT + 1);
        check_eq("fault_set", fault, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mif.imem_ready = 1'b1;
            mif.dmem_ready = 1'b1;
            #1;
            check_eq("fault_quiet", {mif.imem_req, mif.dmem_req, id_en, ex_en, mem_en, wb_en, retire}, 7'b0);
            check_eq("fault_sticky", fault, 1'b1);
            check_eq("fault_pc", pc, m_pc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("clr_fault", fault, 1'b0);
        check_eq("clr_pc", pc, 64'h0);
        check_eq("clr_imem_req", mif.imem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
